// File: rtl/uc_memory.sv
// ---------------------------------------------------------------------------
// uc_memory
//   Word-addressed synchronous RAM that sits directly behind the
//   microcontroller. The controller presents a request (enable, rw, addr,
//   data_in). After WAIT_CYCLES extra cycles the access is performed, and
//   completion is signalled on mfc until the controller drops enable. A
//   backdoor load port writes storage directly, in any state and even
//   while reset is asserted.
//
//   Handshake (enable/mfc):
//     - enable is sampled only in IDLE. The first rising edge with
//       enable=1 accepts the request. addr, rw and data_in are latched on
//       that edge; later changes to them are ignored.
//     - mfc rises WAIT_CYCLES+1 edges after acceptance. It stays high, with
//       data_out stable, for as long as enable stays high.
//     - The edge that samples enable=0 in DONE clears mfc and returns the
//       block to IDLE. A new request can only be accepted from IDLE.
//     - If enable drops while the access is still waiting, the access
//       still completes. mfc is then high for exactly one cycle.
//
//   Optional feature (macro UC_MEM_RANGE_CHECK_EN):
//     A request with any address bit at or above ADDR_BITS set is flagged
//     out of range. It keeps normal timing, writes nothing, and a read
//     returns 0. The extra output err is high together with mfc for such
//     a request. Without the macro, the upper address bits simply wrap.
//
//   Ports:
//     clk        clock, rising edge
//     reset      asynchronous reset, active low
//     enable     access request, held until mfc is seen
//     rw         1 = read, 0 = write (sampled with enable in IDLE)
//     addr       16-bit word address
//     data_in    write data
//     data_out   read data (holds the last read value)
//     mfc        memory function complete
//     err        out-of-range flag (only with UC_MEM_RANGE_CHECK_EN)
//     load_en    backdoor write strobe
//     load_addr  backdoor write index
//     load_data  backdoor write data
//     state_dbg  current FSM state (0 = IDLE, 1 = BUSY, 2 = DONE)
// ---------------------------------------------------------------------------
module uc_memory #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_BITS   = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  rw,
  input  logic [15:0]           addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  mfc,
`ifdef UC_MEM_RANGE_CHECK_EN
  output logic                  err,
`endif
  input  logic                  load_en,
  input  logic [ADDR_BITS-1:0]  load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [1:0]            state_dbg
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]      wait_cnt;
  logic [ADDR_BITS-1:0]  req_idx;
  logic                  req_rw;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  req_oor;
  logic                  accept;
  logic                  commit;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign accept = (state == IDLE) && enable;
  assign commit = (state == BUSY) && (wait_cnt == '0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = BUSY;
      BUSY:    if (wait_cnt == '0) state_nxt = DONE;
      DONE:    if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. mfc is a pure function of the state register, so it drops as
  // soon as reset forces the state back to IDLE.
  always_comb begin
    mfc       = (state == DONE);
    state_dbg = state;
  end

`ifdef UC_MEM_RANGE_CHECK_EN
  assign err = mfc && req_oor;
`endif

  // Request capture, wait counter and read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      req_idx  <= '0;
      req_rw   <= 1'b0;
      req_data <= '0;
      data_out <= '0;
    end else begin
      if (accept) begin
        wait_cnt <= CNT_W'(WAIT_CYCLES);
        req_idx  <= addr[ADDR_BITS-1:0];
        req_rw   <= rw;
        req_data <= data_in;
      end else if ((state == BUSY) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - CNT_W'(1);
      end
      // The read samples storage before this edge's writes land, so a
      // backdoor load on the same edge is not visible yet.
      if (commit && req_rw) begin
        data_out <= req_oor ? '0 : mem[req_idx];
      end
    end
  end

`ifdef UC_MEM_RANGE_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_oor <= 1'b0;
    end else if (accept) begin
      req_oor <= |addr[15:ADDR_BITS];
    end
  end
`else
  // Upper address bits wrap; they play no part in the access.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[15:ADDR_BITS];
  assign req_oor        = 1'b0;
`endif

  // Storage has no reset: contents survive reset, and the backdoor load
  // stays live while reset is asserted. commit cannot be true during reset
  // because the state is held in IDLE, so an aborted write never lands.
  // The load comes last so it wins a same-index collision.
  always_ff @(posedge clk) begin
    if (commit && !req_rw && !req_oor) begin
      mem[req_idx] <= req_data;
    end
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_uc_memory.sv
module tb_uc_memory;

  localparam int DW   = 16;
  localparam int AB   = 8;
  localparam int WAIT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          rw;
  logic [15:0]   addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          mfc;
  logic          load_en;
  logic [AB-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic [1:0]    state_dbg;
`ifdef UC_MEM_RANGE_CHECK_EN
  logic          err;
`endif

  uc_memory #(
    .DATA_WIDTH(DW), .ADDR_BITS(AB), .DEPTH(256), .WAIT_CYCLES(WAIT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .rw(rw), .addr(addr),
    .data_in(data_in), .data_out(data_out), .mfc(mfc),
`ifdef UC_MEM_RANGE_CHECK_EN
    .err(err),
`endif
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(negedge clk) cyc++;

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_err    = 0;

  logic [DW-1:0] ref_mem [256];
  logic          exp_mfc  = 1'b0;
  logic [DW-1:0] exp_dout = '0;
  logic          exp_err  = 1'b0;
  logic [DW-1:0] exp_q[$];    // expected read values, in request order

  // current request as seen by the model
  logic          m_rw;
  logic [AB-1:0] m_idx;
  logic [DW-1:0] m_data;
  logic          m_oor;
  bit            rand_ld = 1'b0;
  int            acc_cyc  = 0;
  int            rise_cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic oor_of(input logic [15:0] a);
`ifdef UC_MEM_RANGE_CHECK_EN
    return (a >= 16'd256);
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model across one rising edge. commit: the request's access
  // takes effect on this edge. leave: mfc goes away on this edge.
  task automatic tick(input bit commit, input bit leave);
    @(posedge clk);
    if (commit) begin
      if (m_rw) begin
        exp_dout = m_oor ? '0 : ref_mem[m_idx];
        exp_q.push_back(exp_dout);
      end else if (!m_oor) begin
        ref_mem[m_idx] = m_data;
      end
      exp_mfc = 1'b1;
      exp_err = m_oor;
    end
    if (leave) begin
      exp_mfc = 1'b0;
      exp_err = 1'b0;
    end
    if (load_en) ref_mem[load_addr] = load_data;
  endtask

  // Compare process: every cycle, just after the active edge.
  logic prev_mfc = 1'b0;
  always @(posedge clk) begin
    #1;
    check("mfc", {31'd0, mfc}, {31'd0, exp_mfc});
    check("data_out", {16'd0, data_out}, {16'd0, exp_dout});
`ifdef UC_MEM_RANGE_CHECK_EN
    check("err", {31'd0, err}, {31'd0, exp_err});
`endif
    if (mfc === 1'b1 && !prev_mfc) rise_cyc = cyc;
    prev_mfc = (mfc === 1'b1);
  end

  // ---------------- driver tasks ----------------
  // Random backdoor traffic plus, optionally, garbage on the request inputs
  // (which the DUT must ignore once a request has been accepted).
  task automatic noise(input bit scramble);
    load_en   = rand_ld && ($urandom_range(0, 3) == 0);
    load_addr = AB'($urandom_range(0, 255));
    load_data = DW'($urandom);
    if (scramble) begin
      addr    = 16'($urandom);
      data_in = DW'($urandom);
      rw      = 1'($urandom);
    end
  endtask

  task automatic do_req(input bit r, input logic [15:0] a, input logic [DW-1:0] d,
                        input bit early, input int hold,
                        input bit force_ld, input logic [AB-1:0] la, input logic [DW-1:0] ld);
    @(negedge clk);
    noise(1'b0);
    enable = 1'b1; rw = r; addr = a; data_in = d;
    m_rw = r; m_idx = a[AB-1:0]; m_data = d; m_oor = oor_of(a);
    tick(1'b0, 1'b0);                      // acceptance edge
    acc_cyc = cyc;
    @(negedge clk);
    noise(1'b1);
    if (early) enable = 1'b0;
    if (WAIT == 0 && force_ld) begin load_en = 1'b1; load_addr = la; load_data = ld; end
    for (int i = 0; i < WAIT; i++) begin
      tick(1'b0, 1'b0);
      @(negedge clk);
      noise(1'b1);
      if (i == WAIT - 1 && force_ld) begin load_en = 1'b1; load_addr = la; load_data = ld; end
    end
    tick(1'b1, 1'b0);                      // access edge
    if (early) begin
      @(negedge clk); noise(1'b1);
      tick(1'b0, 1'b1);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk); noise(1'b1);
        tick(1'b0, 1'b0);
      end
      @(negedge clk); noise(1'b1); enable = 1'b0;
      tick(1'b0, 1'b1);
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic backdoor(input logic [AB-1:0] la, input logic [DW-1:0] ld);
    @(negedge clk);
    load_en = 1'b1; load_addr = la; load_data = ld;
    tick(1'b0, 1'b0);
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic read_expect(input string name, input logic [15:0] a, input logic [DW-1:0] v);
    logic [DW-1:0] q;
    do_req(1'b1, a, '0, 1'b0, 1, 1'b0, '0, '0);
    q = exp_q.pop_back();
    check({name, "_model"}, {16'd0, q}, {16'd0, v});
    check(name, {16'd0, data_out}, {16'd0, v});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] held;
    reset = 1'b0; enable = 1'b0; rw = 1'b0; addr = '0; data_in = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;

    // Preload every word while reset is held, so the model knows all contents.
    for (int i = 0; i < 256; i++) backdoor(AB'(i), DW'($urandom));
    #1;
    check("rst_mfc", {31'd0, mfc}, 32'd0);
    check("rst_data_out", {16'd0, data_out}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Read of a preloaded word, latency pinned by hand.
    backdoor(8'h05, 16'hBEEF);
    read_expect("read_05", 16'h0005, 16'hBEEF);
    check("lat_read", 32'(rise_cyc - acc_cyc), 32'd3);
    check("mfc_after_drop", {31'd0, mfc}, 32'd0);

    // Write; inputs are scrambled after acceptance. data_out must not move.
    held = data_out;
    do_req(1'b0, 16'h0010, 16'h1234, 1'b0, 2, 1'b0, '0, '0);
    check("write_keeps_dout", {16'd0, data_out}, {16'd0, held});
    read_expect("read_10", 16'h0010, 16'h1234);

    // Reset during BUSY aborts the write.
    backdoor(8'h20, 16'h1111);
    @(negedge clk);
    enable = 1'b1; rw = 1'b0; addr = 16'h0020; data_in = 16'h5555;
    tick(1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0; enable = 1'b0;
    exp_mfc = 1'b0; exp_dout = '0; exp_err = 1'b0;
    #1 check("rst_busy_mfc", {31'd0, mfc}, 32'd0);
    tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    read_expect("read_20_after_abort", 16'h0020, 16'h1111);

    // Reset while in DONE: mfc and data_out fall without a clock edge.
    @(negedge clk);
    enable = 1'b1; rw = 1'b1; addr = 16'h0005;
    m_rw = 1'b1; m_idx = 8'h05; m_oor = 1'b0;
    tick(1'b0, 1'b0);
    for (int i = 0; i < WAIT; i++) begin @(negedge clk); tick(1'b0, 1'b0); end
    @(negedge clk); tick(1'b1, 1'b0);
    void'(exp_q.pop_back());
    @(negedge clk);
    check("done_mfc", {31'd0, mfc}, 32'd1);
    #2 reset = 1'b0;
    exp_mfc = 1'b0; exp_dout = '0; exp_err = 1'b0;
    #1;
    check("rst_done_mfc", {31'd0, mfc}, 32'd0);
    check("rst_done_dout", {16'd0, data_out}, 32'd0);
    @(negedge clk);
    enable = 1'b0; reset = 1'b1;

    // Upper address bits: wrap by default, flagged with the range check.
`ifdef UC_MEM_RANGE_CHECK_EN
    read_expect("read_105", 16'h0105, 16'h0000);
    do_req(1'b0, 16'h0105, 16'h7777, 1'b0, 0, 1'b0, '0, '0);
    read_expect("read_05_after_oor_write", 16'h0005, 16'hBEEF);
`else
    read_expect("read_105", 16'h0105, 16'hBEEF);
    do_req(1'b0, 16'h0105, 16'h7777, 1'b0, 0, 1'b0, '0, '0);
    read_expect("read_05_after_wrap_write", 16'h0005, 16'h7777);
`endif

    // Load beats a controller write to the same index on the same edge.
    do_req(1'b0, 16'h0030, 16'h0BAD, 1'b0, 1, 1'b1, 8'h30, 16'hCAFE);
    read_expect("read_30_collision", 16'h0030, 16'hCAFE);

    // A read completing with a same-index load returns the old contents.
    backdoor(8'h40, 16'h4444);
    do_req(1'b1, 16'h0040, '0, 1'b0, 0, 1'b1, 8'h40, 16'h9999);
    check("read_40_old", {16'd0, data_out}, 32'h4444);
    read_expect("read_40_new", 16'h0040, 16'h9999);

    // enable dropped during BUSY: the write still commits, mfc pulses once.
    do_req(1'b0, 16'h0050, 16'hA5A5, 1'b1, 0, 1'b0, '0, '0);
    read_expect("read_50_early_drop", 16'h0050, 16'hA5A5);

    // Random traffic against the model.
    rand_ld = 1'b1;
    for (int n = 0; n < 80; n++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      do_req(1'($urandom), a, DW'($urandom), ($urandom_range(0, 4) == 0),
             $urandom_range(0, 3), 1'b0, '0, '0);
    end
    rand_ld = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uc_memory.md
Name: uc_memory

Overview:
- Word-addressed synchronous RAM sitting directly downstream of the microcontroller top.
- Consumes the controller's MAR address, MBR write data, enable and rw.
- Returns read data to the MBR input path and signals completion on mfc (memory function complete).
- Programmable wait states model slow memory. A backdoor load port lets the bench preload programs.

Parameters:
- DATA_WIDTH, 16, word width of storage and data ports.
- ADDR_BITS, 8, number of low address bits used to index storage.
- DEPTH, 256, number of words; must equal 2**ADDR_BITS.
- WAIT_CYCLES, 2, extra cycles between request acceptance and access; 0 is legal.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- enable  in  1  access request from the controller; held high until mfc is seen.
- rw  in  1  1 = read, 0 = write; sampled with enable.
- addr  in  16  word address from the MAR.
- data_in  in  DATA_WIDTH  write data from the MBR.
- data_out  out  DATA_WIDTH  read data toward the MBR input register.
- mfc  out  1  access complete; high until enable drops.
- load_en  in  1  backdoor write strobe.
- load_addr  in  ADDR_BITS  backdoor write address.
- load_data  in  DATA_WIDTH  backdoor write data.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, mfc=0, data_out=0, wait counter=0.
  - Storage contents are not cleared; they are retained across reset and undefined at power-up.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On a rising edge with enable=1, latch addr, rw and data_in into request registers, load counter=WAIT_CYCLES, go to BUSY.
  - Later changes on addr/data_in are ignored.
- BUSY:
  - If counter != 0: decrement and stay.
  - If counter == 0: perform the access and go to DONE with mfc=1 registered.
    - Read: data_out <= mem[req_addr].
    - Write: mem[req_addr] <= req_data; data_out unchanged.
- Latency: enable first sampled high at edge N → mfc high after edge N+WAIT_CYCLES+1 (WAIT_CYCLES=2: mfc visible after edge N+3).
- DONE:
  - mfc stays 1 and data_out stays stable while enable=1.
  - On the edge sampling enable=0: mfc <= 0, go to IDLE.
  - enable re-asserted on that same edge is not accepted; a new request needs IDLE.
- Minimum request spacing: WAIT_CYCLES+3 cycles.
- enable dropping during BUSY: the access still completes and commits. DONE then exits on the next edge because enable=0, so mfc pulses for one cycle.
- rw is only sampled in IDLE.
- Address mapping: the index is the low ADDR_BITS of the latched addr; upper bits wrap, except as given under Optional Feature.
- data_out holds the last read value until the next read completes.
- Backdoor load:
  - load_en=1 writes load_data to mem[load_addr] on the edge, in any state, including while reset is asserted.
  - If load_en and a controller write target the same index on the same edge, load_data wins.
  - A controller read completing on the same edge as a load to the same index returns the old (pre-load) contents.
- Reset asserted mid-operation: the request is aborted, no pending write is committed, mfc drops immediately (async).

Optional Feature:
- Macro: UC_MEM_RANGE_CHECK_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - A request whose latched addr >= DEPTH (any upper bit set) still walks IDLE→BUSY→DONE with identical timing.
  - It performs no write, and a read sets data_out=0.
  - err=1 for exactly the cycles mfc=1 and clears with mfc. In-range accesses keep err=0.
- Not defined: no err port; out-of-range addresses wrap to the low ADDR_BITS as above.

Test Plan:
- Reset, then backdoor load mem[0x05]=0xBEEF; read request addr=0x0005, rw=1 at edge N (WAIT_CYCLES=2) → mfc high after edge N+3, data_out=0xBEEF; drop enable → mfc low after next edge.
- Write addr=0x0010, data_in=0x1234, changing data_in to 0xFFFF one cycle after acceptance → after mfc/drop, read of 0x0010 returns 0x1234; data_out is unchanged during the write.
- WAIT_CYCLES=0 build: read of preloaded 0x0001=0x00A5 → mfc high after edge N+1, data_out=0x00A5.
- Reset pulsed low during BUSY of a write to 0x0020 (preloaded 0x1111) → mfc=0 immediately; a later read of 0x0020 returns 0x1111.
- Address 0x0105 (default, macro off) read → returns mem[0x05]. With UC_MEM_RANGE_CHECK_EN: data_out=0 and err=1 alongside mfc; a write to 0x0105 leaves mem[0x05] unchanged.
- Simultaneous load_en (addr 0x30, 0xCAFE) and controller write commit to 0x30 with 0x0BAD → later read returns 0xCAFE.
